// File: rtl/dp_ram_march_ctrl.sv
// dp_ram_march_ctrl: March C- self-test sequencer for one dp_ram; optional stop-on-first-mismatch via DP_RAM_MARCH_STOP_ON_FAIL_EN.
module dp_ram_march_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_data_mask_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CMP, FINISH} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t state, state_nx;
  logic [2:0] elem, elem_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] exp_val;
  logic down, last, mism, clr, rec, cmp_wr;
  always_comb begin
    exp_val = {DATA_WIDTH{elem == 3'd2 || elem == 3'd4}};
    down = elem == 3'd3 || elem == 3'd4;
    last = down ? addr == '0 : addr == LAST;
    mism = state == CMP && ram_data_out != exp_val;
    cmp_wr = state == CMP && elem != 3'd5;
    busy = state == WRITE || state == READ || state == CMP;
    done = state == FINISH;
    ram_rd_en = state == READ;
    ram_rd_addr = ram_rd_en ? addr : '0;
    ram_wr_en = state == WRITE || cmp_wr;
    ram_wr_addr = ram_wr_en ? addr : '0;
    ram_data_in = cmp_wr ? ~exp_val : '0;
    ram_data_mask_in = {DATA_WIDTH{ram_wr_en}};
  end
  always_comb begin
    state_nx = state;
    elem_nx = elem;
    addr_nx = addr;
    clr = 1'b0;
    rec = 1'b0;
    if (busy && abort) begin
      state_nx = IDLE;
      elem_nx = '0;
      addr_nx = '0;
      clr = 1'b1;
    end else begin
      case (state)
        IDLE, FINISH: if (start) begin
          state_nx = WRITE;
          elem_nx = '0;
          addr_nx = '0;
          clr = 1'b1;
        end
        WRITE: begin
          addr_nx = addr + 1'b1;
          if (addr == LAST) begin
            state_nx = READ;
            elem_nx = 3'd1;
          end
        end
        READ: state_nx = CMP;
        CMP: begin
          rec = mism;
          state_nx = READ;
          if (!last) addr_nx = down ? addr - 1'b1 : addr + 1'b1;
          else if (elem == 3'd5) state_nx = FINISH;
          else begin
            elem_nx = elem + 3'd1;
            // Elements 3 and 4 walk downward from the top address
            addr_nx = (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
          end
`ifdef DP_RAM_MARCH_STOP_ON_FAIL_EN
          if (mism) state_nx = FINISH;
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      elem <= '0;
      addr <= '0;
    end else begin
      state <= state_nx;
      elem <= elem_nx;
      addr <= addr_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail <= 1'b0;
      err_cnt <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (clr) begin
      fail <= 1'b0;
      err_cnt <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (rec) begin
      fail <= 1'b1;
      err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
      if (!fail) begin
        fail_addr <= addr;
        fail_elem <= elem;
        fail_data <= ram_data_out;
      end
    end
  end
endmodule

// File: tb/tb_dp_ram_march_ctrl.sv
// tb_dp_ram_march_ctrl: bench for dp_ram_march_ctrl with a 1-cycle RAM model and read-data stuck-at fault injection.
module tb_dp_ram_march_ctrl;
`ifdef DP_RAM_MARCH_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, fault = 1'b0;
  logic busy, done, fail, ram_rd_en, ram_wr_en;
  logic [7:0] err_cnt, fail_data, ram_data_in, ram_data_mask_in, ram_data_out;
  logic [3:0] fail_addr, ram_rd_addr, ram_wr_addr;
  logic [2:0] fail_elem;
  dp_ram_march_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .fail(fail), .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_data(fail_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_data_mask_in(ram_data_mask_in), .ram_data_out(ram_data_out)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [16];
  logic [7:0] rq = 8'h00;
  logic [3:0] ra_q = 4'h0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= (mem[ram_wr_addr] & ~ram_data_mask_in) | (ram_data_in & ram_data_mask_in);
    if (ram_rd_en) begin
      rq <= mem[ram_rd_addr];
      ra_q <= ram_rd_addr;
    end
  end
  assign ram_data_out = rq | ((fault && ra_q == 4'd5) ? 8'h08 : 8'h00);
  logic [25:0] ram_outs;
  logic [51:0] all_outs;
  assign ram_outs = {ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_data_in, ram_data_mask_in};
  assign all_outs = {ram_outs, busy, done, fail, err_cnt, fail_addr, fail_elem, fail_data};
  int total = 0, passed = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask
  logic [25:0] q[$];
  function automatic logic [25:0] op(input bit rd, input int ra, input bit wr, input int wa, input logic [7:0] d);
    logic [3:0] r4, w4;
    r4 = ra[3:0];
    w4 = wa[3:0];
    return {rd, r4, wr, w4, d, {8{wr}}};
  endfunction
  task automatic push_march();
    int a;
    logic [7:0] x;
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(op(0, 0, 1, i, 8'h00));
    for (int e = 1; e <= 5; e++)
      for (int i = 0; i < 16; i++) begin
        a = (e == 3 || e == 4) ? 15 - i : i;
        x = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        q.push_back(op(1, a, 0, 0, 8'h00));
        q.push_back(e < 5 ? op(0, 0, 1, a, ~x) : op(0, 0, 0, 0, 8'h00));
      end
  endtask
  task automatic check_op(input int n);
    if (q.size() == 0) chk($sformatf("op_overrun_c%0d", n), {38'd0, ram_outs}, 64'd0);
    else chk($sformatf("op_c%0d", n), {38'd0, ram_outs}, {38'd0, q.pop_front()});
  endtask
  typedef struct {
    bit fault;
    int abort_at, start_at, busy_cyc;
    int done, fail, err, faddr, felem, fdata;
  } vec_t;
  vec_t vecs[5];
  initial begin
    int n;
    vecs[0] = '{0, -1, -1, 176, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{1, -1, -1, STOP ? 28 : 176, 1, 1, STOP ? 1 : 3, 5, 1, 8};
    vecs[2] = '{0, -1, 10, 176, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 50, -1, STOP ? 28 : 51, STOP, STOP, STOP, STOP ? 5 : 0, STOP, STOP ? 8 : 0};
    vecs[4] = '{0, -1, -1, 176, 1, 0, 0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset_outs", {12'd0, all_outs}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {12'd0, all_outs}, 64'd0);
    for (int v = 0; v < 5; v++) begin
      fault = vecs[v].fault;
      push_march();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 400) begin
        if (n == 0) chk($sformatf("v%0d_clr_on_start", v), {fail, err_cnt}, 9'd0);
        check_op(n);
        abort = (n == vecs[v].abort_at);
        start = (n == vecs[v].start_at);
        n++;
        @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      chk($sformatf("v%0d_busy_cycles", v), n, vecs[v].busy_cyc);
      chk($sformatf("v%0d_done", v), done, vecs[v].done);
      chk($sformatf("v%0d_fail", v), fail, vecs[v].fail);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].err);
      chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].faddr);
      chk($sformatf("v%0d_fail_elem", v), fail_elem, vecs[v].felem);
      chk($sformatf("v%0d_fail_data", v), fail_data, vecs[v].fdata);
      chk($sformatf("v%0d_ram_idle", v), ram_outs, 26'd0);
      @(negedge clk);
      chk($sformatf("v%0d_ram_idle_later", v), {ram_outs, busy}, 27'd0);
    end
    fault = 1'b0;
    push_march();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 21; c++) begin
      check_op(c);
      @(negedge clk);
    end
    chk("cmp_before_reset", {ram_rd_en, ram_wr_en, busy}, 3'b011);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", {12'd0, all_outs}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {12'd0, all_outs}, 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
